// File: rtl/led_level_sequencer.sv
// led_level_sequencer
//
// Converts ADS1115 conversion results into a bar-graph LED pattern and writes it to an
// Avalon-MM LED PIO slave. A write is issued only when the pattern changes, or on the
// first opportunity after reset. Each write is followed by a hold-off period during which
// no new samples are accepted. A host override can force a chosen pattern onto the LEDs.
//
// Parameters
//   HOLDOFF_CYCLES  idle cycles enforced after each PIO write (minimum 1)
//   PIO_ADDR        Avalon-MM address of the PIO data register
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   sample_valid    ADC sample strobe
//   sample_data     ADC conversion result, two's complement
//   sample_ready    high when a sample is accepted this cycle (IDLE only)
//   ovr_en          host override enable
//   ovr_pattern     host-forced LED pattern
//   pio_address     Avalon-MM address, constant PIO_ADDR
//   pio_chipselect  Avalon-MM chipselect, registered
//   pio_write_n     Avalon-MM write strobe, active-low, registered
//   pio_writedata   Avalon-MM write data, registered
//   last_pattern    pattern most recently written to the PIO
//   busy            high whenever the sequencer is not idle

module led_level_sequencer #(
    parameter int unsigned HOLDOFF_CYCLES = 50000,
    parameter logic [1:0]  PIO_ADDR       = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    input  logic        ovr_en,
    input  logic [6:0]  ovr_pattern,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic [6:0]  last_pattern,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(HOLDOFF_CYCLES) + 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StHold
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            force_write_q;
    logic [6:0]      target_q;
    logic [6:0]      last_pattern_q;
    logic            chipselect_q;
    logic            write_n_q;
    logic [31:0]     writedata_q;

    logic       sample_fire;
    logic [6:0] mapped_pattern;
    logic       start_write;
    logic [6:0] start_target;

    // Only the sign bit and the top three magnitude bits select the bar length.
    logic unused_sample_bits;
    assign unused_sample_bits = ^sample_data[11:0];

    assign sample_ready = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign sample_fire  = sample_valid && sample_ready;

    // Negative readings blank the bar; otherwise light the low n bits, n = data[14:12].
    always_comb begin
        mapped_pattern = 7'h00;
        if (!sample_data[15]) begin
            mapped_pattern = 7'((8'd1 << sample_data[14:12]) - 8'd1);
        end
    end

    // Write decision for the IDLE state. Override takes priority and swallows any
    // sample arriving in the same cycle.
    always_comb begin
        start_write  = 1'b0;
        start_target = ovr_pattern;
        if (ovr_en) begin
            start_write = (ovr_pattern != last_pattern_q) || force_write_q;
        end else begin
            start_target = mapped_pattern;
            start_write  = sample_fire &&
                           ((mapped_pattern != last_pattern_q) || force_write_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            force_write_q  <= 1'b1;
            target_q       <= 7'h00;
            last_pattern_q <= 7'h00;
            chipselect_q   <= 1'b0;
            write_n_q      <= 1'b1;
            writedata_q    <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_write) begin
                        state_q      <= StWrite;
                        target_q     <= start_target;
                        chipselect_q <= 1'b1;
                        write_n_q    <= 1'b0;
                        writedata_q  <= {25'b0, start_target};
                    end
                end
                StWrite: begin
                    // Single-cycle strobe; commit the pattern as the bus cycle ends.
                    state_q        <= StHold;
                    cnt_q          <= HoldLoad;
                    last_pattern_q <= target_q;
                    force_write_q  <= 1'b0;
                    chipselect_q   <= 1'b0;
                    write_n_q      <= 1'b1;
                    writedata_q    <= 32'h0;
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    chipselect_q <= 1'b0;
                    write_n_q    <= 1'b1;
                    writedata_q  <= 32'h0;
                end
            endcase
        end
    end

    assign pio_address    = PIO_ADDR;
    assign pio_chipselect = chipselect_q;
    assign pio_write_n    = write_n_q;
    assign pio_writedata  = writedata_q;
    assign last_pattern   = last_pattern_q;

endmodule

// File: tb/tb_led_level_sequencer.sv
module tb_led_level_sequencer;

    localparam int unsigned HOLD = 4;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_ready;
    logic        ovr_en;
    logic [6:0]  ovr_pattern;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [6:0]  last_pattern;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    led_level_sequencer #(
        .HOLDOFF_CYCLES(HOLD),
        .PIO_ADDR      (2'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .sample_ready  (sample_ready),
        .ovr_en        (ovr_en),
        .ovr_pattern   (ovr_pattern),
        .pio_address   (pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n   (pio_write_n),
        .pio_writedata (pio_writedata),
        .last_pattern  (last_pattern),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic        oen;
        logic [6:0]  opat;
        logic        rdy;
        logic        cs;
        logic [6:0]  wd;
        logic [6:0]  last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [15:0] data,
                       input logic oen, input logic [6:0] opat, input logic rdy,
                       input logic cs, input logic [6:0] wd, input logic [6:0] last);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.oen = oen; v.opat = opat;
        v.rdy = rdy; v.cs = cs; v.wd = wd; v.last = last;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic cs,
                             input logic [6:0] wd, input logic [6:0] last);
        check({tag, " ready"}, 32'(sample_ready), 32'(rdy));
        check({tag, " busy"}, 32'(busy), 32'(!rdy));
        check({tag, " chipselect"}, 32'(pio_chipselect), 32'(cs));
        check({tag, " write_n"}, 32'(pio_write_n), 32'(!cs));
        check({tag, " writedata"}, pio_writedata, cs ? {25'b0, wd} : 32'h0);
        check({tag, " last_pattern"}, 32'(last_pattern), 32'(last));
        check({tag, " address"}, 32'(pio_address), 32'h0);
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [15:0] data,
                         input logic oen, input logic [6:0] opat);
        reset = rst; sample_valid = vld; sample_data = data; ovr_en = oen; ovr_pattern = opat;
    endtask

    // Bar length of a reading: count of lit LEDs from the top magnitude bits.
    function automatic logic [6:0] level_of(input logic [15:0] d);
        logic [6:0] p;
        int n;
        p = 7'h00;
        if (d[15] == 1'b0) begin
            n = int'(d[14:12]);
            for (int k = 0; k < n; k++) p[k] = 1'b1;
        end
        return p;
    endfunction

    // Reference model: cycles remaining with ready low, plus the committed pattern.
    int         m_blocked;
    logic [6:0] m_last;
    logic [6:0] m_pend;
    bit         m_force;

    task automatic model_step(input logic rst, input logic vld, input logic [15:0] data,
                              input logic oen, input logic [6:0] opat);
        logic [6:0] want;
        if (rst) begin
            m_blocked = 0; m_last = 7'h00; m_force = 1'b1;
        end else if (m_blocked > 0) begin
            if (m_blocked == int'(HOLD) + 1) begin
                m_last  = m_pend;
                m_force = 1'b0;
            end
            m_blocked--;
        end else if (oen || vld) begin
            want = oen ? opat : level_of(data);
            if (want != m_last || m_force) begin
                m_pend    = want;
                m_blocked = int'(HOLD) + 1;
            end
        end
    endtask

    initial begin
        int low;
        logic [6:0] pat_set [4];
        logic r, v, oe;
        logic [15:0] d;
        logic [6:0] op;

        // rst vld data     oen opat  | rdy cs wd     last
        add(1, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);
        add(0, 1, 16'h3000, 0, 7'h00,   0, 1, 7'h07, 7'h00);
        add(0, 0, 16'h0000, 0, 7'h00,   0, 0, 7'h00, 7'h07);
        add(0, 1, 16'h8000, 1, 7'h55,   0, 0, 7'h00, 7'h07);
        add(0, 0, 16'h0000, 0, 7'h00,   0, 0, 7'h00, 7'h07);
        add(0, 0, 16'h0000, 0, 7'h00,   0, 0, 7'h00, 7'h07);
        add(0, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h07);
        add(0, 1, 16'h3FFF, 0, 7'h00,   1, 0, 7'h00, 7'h07);
        add(0, 1, 16'h3FFF, 0, 7'h00,   1, 0, 7'h00, 7'h07);
        add(0, 1, 16'h8000, 0, 7'h00,   0, 1, 7'h00, 7'h07);
        for (int i = 0; i < 4; i++) add(0, 0, 16'h0000, 0, 7'h00, 0, 0, 7'h00, 7'h00);
        add(0, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);
        add(0, 1, 16'h7FFF, 0, 7'h00,   0, 1, 7'h7F, 7'h00);
        for (int i = 0; i < 4; i++) add(0, 0, 16'h0000, 0, 7'h00, 0, 0, 7'h00, 7'h7F);
        add(0, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h7F);
        add(0, 1, 16'h7FFF, 1, 7'h55,   0, 1, 7'h55, 7'h7F);
        for (int i = 0; i < 4; i++) add(0, 0, 16'h0000, 1, 7'h55, 0, 0, 7'h00, 7'h55);
        add(0, 0, 16'h0000, 1, 7'h55,   1, 0, 7'h00, 7'h55);
        add(0, 0, 16'h0000, 1, 7'h55,   1, 0, 7'h00, 7'h55);
        add(0, 1, 16'h1000, 1, 7'h55,   1, 0, 7'h00, 7'h55);
        add(0, 1, 16'h1000, 0, 7'h00,   0, 1, 7'h01, 7'h55);
        add(0, 0, 16'h0000, 0, 7'h00,   0, 0, 7'h00, 7'h01);
        add(1, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);
        add(0, 1, 16'h0000, 0, 7'h00,   0, 1, 7'h00, 7'h00);
        add(0, 0, 16'h0000, 0, 7'h00,   0, 0, 7'h00, 7'h00);
        add(1, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);
        add(0, 1, 16'h7FFF, 0, 7'h00,   0, 1, 7'h7F, 7'h00);
        add(1, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);
        add(0, 0, 16'h0000, 0, 7'h00,   1, 0, 7'h00, 7'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].oen, vecs[i].opat);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].cs, vecs[i].wd,
                      vecs[i].last);
        end

        // Ready-low window after a write-causing transfer (force_write set by last reset).
        drive(0, 1, 16'h2000, 0, 7'h00);
        @(posedge clk);
        #1;
        drive(0, 0, 16'h0000, 0, 7'h00);
        check("hold strobe", {pio_chipselect, pio_write_n, pio_writedata[29:0]},
              {1'b1, 1'b0, 30'h03});
        low = 0;
        while (!sample_ready && low < 20) begin
            low++;
            @(posedge clk);
            #1;
        end
        check("hold ready_low_cycles", 32'(low), HOLD + 1);
        check("hold last_pattern", 32'(last_pattern), 32'h03);

        // Randomized run against the reference model.
        pat_set[0] = 7'h00; pat_set[1] = 7'h07; pat_set[2] = 7'h55; pat_set[3] = 7'h7F;
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 7'h00);
        model_step(1, 0, 16'h0000, 0, 7'h00);
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 149) == 0);
            v  = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            oe = ($urandom_range(0, 5) == 0);
            op = ($urandom_range(0, 1) == 1) ? pat_set[$urandom_range(0, 3)]
                                              : 7'($urandom_range(0, 127));
            drive(r, v, d, oe, op);
            model_step(r, v, d, oe, op);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("rand%0d", c), m_blocked == 0, m_blocked == int'(HOLD) + 1,
                      m_pend, m_last);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_level_sequencer.md
LED_LEVEL_SEQUENCER -- requirements
Module: led_level_sequencer

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 50000, minimum 1: idle cycles enforced after each PIO write.
REQ-002 Parameter PIO_ADDR, default 0, 2 bits: PIO data register address.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  ADC sample strobe.
REQ-007 sample_data  in  16  ADS1115 conversion result, two's complement.
REQ-008 sample_ready  out  1  block accepts a sample this cycle.
REQ-009 ovr_en  in  1  host override enable.
REQ-010 ovr_pattern  in  7  host-forced LED pattern.
REQ-011 pio_address  out  2  Avalon-MM address to the LED PIO slave.
REQ-012 pio_chipselect  out  1  Avalon-MM chipselect.
REQ-013 pio_write_n  out  1  Avalon-MM write strobe, active-low.
REQ-014 pio_writedata  out  32  Avalon-MM write data.
REQ-015 last_pattern  out  7  pattern most recently written to the PIO.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, WRITE and HOLD.
REQ-018 Sample handshake: a transfer occurs when sample_valid and sample_ready are both high on a rising edge.
REQ-019 sample_ready SHALL be 1 in IDLE and 0 in WRITE and HOLD.
REQ-020 Mapping: sample_data[15]=1 -> pattern 7'h00.
REQ-021 Mapping: otherwise, with n = sample_data[14:12], the pattern SHALL set the low n bits (e.g. n=3 -> 7'h07, n=7 -> 7'h7F).
REQ-022 Change filter: an internal force_write flag is set by reset and cleared by every WRITE.
REQ-023 In IDLE with ovr_en=1: if ovr_pattern differs from last_pattern, or force_write=1, the next state SHALL be WRITE with target ovr_pattern.
REQ-024 In IDLE with ovr_en=1: any sample transferred that cycle SHALL be consumed and discarded; override has priority over samples in the same cycle.
REQ-025 In IDLE with ovr_en=0: on a transfer, if the mapped pattern differs from last_pattern, or force_write=1, the next state SHALL be WRITE.
REQ-026 In IDLE with ovr_en=0: on a transfer with a matching pattern and force_write=0, the sample SHALL be consumed and the state SHALL remain IDLE with no bus write.
REQ-027 WRITE lasts exactly one cycle and SHALL drive: pio_chipselect=1, pio_write_n=0, pio_writedata={25'b0,target}.
REQ-028 On the edge leaving WRITE, last_pattern SHALL be updated to target.
REQ-029 All bus outputs SHALL be registered.
REQ-030 Outside WRITE: pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-031 pio_address SHALL equal PIO_ADDR at all times.
REQ-032 WRITE SHALL always go to HOLD, loading the hold counter with HOLDOFF_CYCLES-1.
REQ-033 The hold counter width SHALL be clog2(HOLDOFF_CYCLES)+1 bits.
REQ-034 HOLD SHALL decrement the counter each cycle and go to IDLE on the cycle after the counter reaches 0.
REQ-035 ovr_en and ovr_pattern SHALL be ignored outside IDLE and re-evaluated on return to IDLE.
REQ-036 Timing: a transfer at edge A puts the WRITE strobe in cycle A+1, HOLD in cycles A+2 .. A+1+HOLDOFF_CYCLES, and IDLE at A+2+HOLDOFF_CYCLES.
REQ-037 Consequence of REQ-036: sample_ready SHALL be low for exactly HOLDOFF_CYCLES+1 cycles after each write-causing transfer.
REQ-038 Non-writing transfers SHALL leave sample_ready high, allowing back-to-back transfers.

Reset
REQ-039 While reset is high at an edge: state<-IDLE, pio_chipselect<-0, pio_write_n<-1, pio_writedata<-0, last_pattern<-0, counter<-0, force_write<-1.
REQ-040 Reset high at an edge also sets busy=0 and sample_ready=1 on the following cycle.
REQ-041 Reset in WRITE or HOLD SHALL abort the operation at that edge; no partial or repeated write follows.

Verification (HOLDOFF_CYCLES=4, PIO_ADDR=0)
REQ-042 Reset, then sample 16'h3000 -> one-cycle write of 32'h07 at address 0; last_pattern=7'h07; sample_ready low for 5 cycles.
REQ-043 After REQ-042, sample 16'h3FFF -> consumed, no write, sample_ready stays 1, last_pattern=7'h07.
REQ-044 Samples 16'h8000 then 16'h7FFF -> writes 32'h00 then 32'h7F, each followed by 5 cycles with ready=0.
REQ-045 ovr_en=1, ovr_pattern=7'h55, with sample_valid=1 (16'h7FFF) in the same IDLE cycle -> sample consumed, single write 32'h55.
REQ-046 After REQ-045, hold ovr_en=1 with the same pattern -> no further writes; drop ovr_en, then sample 16'h1000 -> write 32'h01.
REQ-047 Reset asserted during HOLD -> next cycle IDLE with ready=1; then sample 16'h0000 -> write 32'h00 (force_write), despite last_pattern=0.
